// File: rtl/nts_ntp_header_rx_pkg.sv
// Shared definitions for the NTP header receiver: API map, core identity,
// FSM encoding and the bit positions of the NTP header fields in block 0.
package nts_ntp_header_rx_pkg;

    localparam logic [7:0] API_ADDR_NAME0   = 8'h00;
    localparam logic [7:0] API_ADDR_NAME1   = 8'h01;
    localparam logic [7:0] API_ADDR_VERSION = 8'h02;
    localparam logic [7:0] API_ADDR_OK_CNT  = 8'h10;
    localparam logic [7:0] API_ADDR_BAD_CNT = 8'h11;
    localparam logic [7:0] API_ADDR_CLEAR   = 8'h12;

    localparam logic [31:0] CORE_NAME0   = 32'h6e74_7068;
    localparam logic [31:0] CORE_NAME1   = 32'h6864_7278;
    localparam logic [31:0] CORE_VERSION = 32'h302e_3031;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_DONE    = 2'd2,
        ST_ERROR   = 2'd3
    } rx_state_t;

    // Field positions inside the big-endian 64-bit block 0
    localparam int VN_MSB   = 61;
    localparam int VN_LSB   = 59;
    localparam int MODE_MSB = 58;
    localparam int MODE_LSB = 56;
    localparam int POLL_MSB = 47;
    localparam int POLL_LSB = 40;

    localparam logic [2:0] VN_LOW      = 3'd3;
    localparam logic [2:0] VN_HIGH     = 3'd4;
    localparam logic [2:0] MODE_CLIENT = 3'd3;

    function automatic logic header_acceptable(input logic [2:0] vn, input logic [2:0] mode);
        return ((vn == VN_LOW) || (vn == VN_HIGH)) && (mode == MODE_CLIENT);
    endfunction

endpackage

// File: rtl/nts_ntp_header_rx.sv
// Receives the NTP header of a packet as a sequence of 64-bit blocks,
// captures VN/Mode/Poll and the origin timestamp, and reports a verdict.
module nts_ntp_header_rx
    import nts_ntp_header_rx_pkg::*;
#(
    parameter int NTP_HEADER_BLOCKS = 6
) (
    input  logic        i_clk,
    input  logic        i_areset,
    input  logic        i_clear,
    input  logic        i_rx_wr_en,
    input  logic [2:0]  i_rx_block,
    input  logic [63:0] i_rx_data,
    output logic        o_busy,
    output logic        o_record_receive_timestamp,
    output logic        o_done,
    output logic        o_valid,
    output logic        o_error,
    output logic [2:0]  o_version_number,
    output logic [2:0]  o_mode,
    output logic [7:0]  o_poll,
    output logic [63:0] o_origin_timestamp,
    input  logic        i_api_cs,
    input  logic        i_api_we,
    input  logic [7:0]  i_api_address,
    input  logic [31:0] i_api_write_data,
    output logic [31:0] o_api_read_data
);

    localparam logic [2:0] LAST_BLOCK = 3'(NTP_HEADER_BLOCKS - 1);

    rx_state_t   state_r;
    rx_state_t   state_next_s;
    logic [2:0]  expected_r;
    logic [2:0]  expected_next_s;
    logic        accept_b0_s;
    logic        capture_origin_s;
    logic        ok_inc_s;
    logic        bad_inc_s;
    logic        api_clear_s;
    logic [31:0] ok_cnt_r;
    logic [31:0] bad_cnt_r;

    logic        busy_r;
    logic        rec_ts_r;
    logic        done_r;
    logic        valid_r;
    logic        error_r;
    logic [2:0]  vn_r;
    logic [2:0]  mode_r;
    logic [7:0]  poll_r;
    logic [63:0] origin_r;

    // Write data carries no meaning: the only write is the counter clear
    logic        unused_s;
    assign unused_s = ^i_api_write_data;

    assign api_clear_s = i_api_cs && i_api_we && (i_api_address == API_ADDR_CLEAR);

    // Next-state, block sequencing and counter events
    always_comb begin
        state_next_s     = state_r;
        expected_next_s  = expected_r;
        accept_b0_s      = 1'b0;
        capture_origin_s = 1'b0;
        ok_inc_s         = 1'b0;
        bad_inc_s        = 1'b0;
        if (i_clear) begin
            state_next_s    = ST_IDLE;
            expected_next_s = 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_rx_wr_en && (i_rx_block == 3'd0)) begin
                        accept_b0_s     = 1'b1;
                        expected_next_s = 3'd1;
                        state_next_s    = ST_RECEIVE;
                    end else if (i_rx_wr_en) begin
                        bad_inc_s       = 1'b1;
                        expected_next_s = 3'd0;
                        state_next_s    = ST_ERROR;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_RECEIVE: begin
                    if (i_rx_wr_en && (i_rx_block == expected_r)) begin
                        expected_next_s = expected_r + 3'd1;
                        if (expected_r == LAST_BLOCK) begin
                            capture_origin_s = 1'b1;
                            state_next_s     = ST_DONE;
                        end else begin
                            state_next_s = ST_RECEIVE;
                        end
                    end else if (i_rx_wr_en) begin
                        bad_inc_s       = 1'b1;
                        expected_next_s = 3'd0;
                        state_next_s    = ST_ERROR;
                    end else begin
                        state_next_s = ST_RECEIVE;
                    end
                end
                ST_DONE: begin
                    // valid_r holds the verdict currently shown on o_valid
                    ok_inc_s        = valid_r;
                    bad_inc_s       = ~valid_r;
                    expected_next_s = 3'd0;
                    state_next_s    = ST_IDLE;
                end
                ST_ERROR: begin
                    state_next_s = ST_ERROR;
                end
                default: begin
                    expected_next_s = 3'd0;
                    state_next_s    = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state and status outputs, registered from the next state
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_r    <= ST_IDLE;
            expected_r <= 3'd0;
            busy_r     <= 1'b0;
            rec_ts_r   <= 1'b0;
            done_r     <= 1'b0;
            valid_r    <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            expected_r <= expected_next_s;
            busy_r     <= (state_next_s != ST_IDLE);
            rec_ts_r   <= accept_b0_s;
            done_r     <= (state_next_s == ST_DONE);
            valid_r    <= (state_next_s == ST_DONE) && header_acceptable(vn_r, mode_r);
            error_r    <= (state_next_s == ST_ERROR);
        end
    end

    // Captured header fields persist across clears until the next block 0
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            vn_r     <= 3'd0;
            mode_r   <= 3'd0;
            poll_r   <= 8'd0;
            origin_r <= 64'd0;
        end else begin
            if (accept_b0_s) begin
                vn_r   <= i_rx_data[VN_MSB:VN_LSB];
                mode_r <= i_rx_data[MODE_MSB:MODE_LSB];
                poll_r <= i_rx_data[POLL_MSB:POLL_LSB];
            end
            if (capture_origin_s) begin
                origin_r <= i_rx_data;
            end
        end
    end

    // Packet statistics; the API clear overrides a same-cycle count event
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            ok_cnt_r  <= 32'd0;
            bad_cnt_r <= 32'd0;
        end else if (api_clear_s) begin
            ok_cnt_r  <= 32'd0;
            bad_cnt_r <= 32'd0;
        end else begin
            if (ok_inc_s) begin
                ok_cnt_r <= ok_cnt_r + 32'd1;
            end
            if (bad_inc_s) begin
                bad_cnt_r <= bad_cnt_r + 32'd1;
            end
        end
    end

    // Combinational API read decode
    always_comb begin
        o_api_read_data = 32'd0;
        case (i_api_address)
            API_ADDR_NAME0:   o_api_read_data = CORE_NAME0;
            API_ADDR_NAME1:   o_api_read_data = CORE_NAME1;
            API_ADDR_VERSION: o_api_read_data = CORE_VERSION;
            API_ADDR_OK_CNT:  o_api_read_data = ok_cnt_r;
            API_ADDR_BAD_CNT: o_api_read_data = bad_cnt_r;
            default:          o_api_read_data = 32'd0;
        endcase
    end

    assign o_busy                     = busy_r;
    assign o_record_receive_timestamp = rec_ts_r;
    assign o_done                     = done_r;
    assign o_valid                    = valid_r;
    assign o_error                    = error_r;
    assign o_version_number           = vn_r;
    assign o_mode                     = mode_r;
    assign o_poll                     = poll_r;
    assign o_origin_timestamp         = origin_r;

endmodule

// File: tb/tb_nts_ntp_header_rx.sv
// Directed bench for nts_ntp_header_rx: verdicts go through a scoreboard
// queue filled when the last block is driven and drained on o_done.
module tb_nts_ntp_header_rx;

    typedef struct packed {
        logic        valid;
        logic [63:0] origin;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_areset;
    logic        i_clear;
    logic        i_rx_wr_en;
    logic [2:0]  i_rx_block;
    logic [63:0] i_rx_data;
    logic        o_busy;
    logic        o_record_receive_timestamp;
    logic        o_done;
    logic        o_valid;
    logic        o_error;
    logic [2:0]  o_version_number;
    logic [2:0]  o_mode;
    logic [7:0]  o_poll;
    logic [63:0] o_origin_timestamp;
    logic        i_api_cs;
    logic        i_api_we;
    logic [7:0]  i_api_address;
    logic [31:0] i_api_write_data;
    logic [31:0] o_api_read_data;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [31:0] exp_ok;
    logic [31:0] exp_bad;

    localparam logic [63:0] B0_GOOD  = 64'h2300_0600_0000_0000;
    localparam logic [63:0] B0_MODE4 = 64'h2400_0600_0000_0000;
    localparam logic [63:0] B0_VN3   = 64'h1B00_0A00_0000_0000;
    localparam logic [63:0] ORIGIN1  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] ORIGIN2  = 64'hFEDC_BA98_7654_3210;

    nts_ntp_header_rx #(.NTP_HEADER_BLOCKS(6)) dut (
        .i_clk                      (i_clk),
        .i_areset                   (i_areset),
        .i_clear                    (i_clear),
        .i_rx_wr_en                 (i_rx_wr_en),
        .i_rx_block                 (i_rx_block),
        .i_rx_data                  (i_rx_data),
        .o_busy                     (o_busy),
        .o_record_receive_timestamp (o_record_receive_timestamp),
        .o_done                     (o_done),
        .o_valid                    (o_valid),
        .o_error                    (o_error),
        .o_version_number           (o_version_number),
        .o_mode                     (o_mode),
        .o_poll                     (o_poll),
        .o_origin_timestamp         (o_origin_timestamp),
        .i_api_cs                   (i_api_cs),
        .i_api_we                   (i_api_we),
        .i_api_address              (i_api_address),
        .i_api_write_data           (i_api_write_data),
        .o_api_read_data            (o_api_read_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge and drain the scoreboard on o_done
    task automatic tick();
        exp_t e;
        @(posedge i_clk);
        #1;
        if (o_done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(o_done), 64'd0);
            end else begin
                e = sb.pop_front();
                check("verdict_valid", 64'(o_valid), 64'(e.valid));
                check("verdict_origin", o_origin_timestamp, e.origin);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send_block(input logic [2:0] blk, input logic [63:0] data);
        i_rx_wr_en = 1'b1;
        i_rx_block = blk;
        i_rx_data  = data;
        tick();
        i_rx_wr_en = 1'b0;
        i_rx_block = 3'd0;
        i_rx_data  = 64'd0;
    endtask

    function automatic logic model_ok(input logic [63:0] b0);
        logic [2:0] vn;
        logic [2:0] mode;
        vn   = b0[61:59];
        mode = b0[58:56];
        return ((vn == 3'd3) || (vn == 3'd4)) && (mode == 3'd3);
    endfunction

    task automatic read_api(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        i_api_address = addr;
        #1;
        check(tag, 64'(o_api_read_data), 64'(exp));
    endtask

    task automatic write_api(input logic [7:0] addr, input logic [31:0] data);
        i_api_cs         = 1'b1;
        i_api_we         = 1'b1;
        i_api_address    = addr;
        i_api_write_data = data;
        tick();
        i_api_cs         = 1'b0;
        i_api_we         = 1'b0;
        i_api_write_data = 32'd0;
    endtask

    task automatic send_blocks_0_to_4(input logic [63:0] b0, input int gap);
        send_block(3'd0, b0);
        for (int b = 1; b <= 4; b++) begin
            send_block(3'(b), {32'hB10C_0000, 32'(b)});
            if (b == 2) idle(gap);
        end
    endtask

    // Full packet: the verdict must appear in the cycle right after block 5
    task automatic send_packet(input logic [63:0] b0, input logic [63:0] origin, input int gap);
        logic ok;
        ok = model_ok(b0);
        send_blocks_0_to_4(b0, gap);
        sb.push_back({ok, origin});
        send_block(3'd5, origin);
        check("done_pulse", 64'(o_done), 64'd1);
        check("done_latency", 64'(sb.size()), 64'd0);
        if (ok) exp_ok = exp_ok + 32'd1;
        else    exp_bad = exp_bad + 32'd1;
        tick();
        check("done_one_cycle", 64'(o_done), 64'd0);
        check("idle_after_done", 64'(o_busy), 64'd0);
        read_api("ok_count", 8'h10, exp_ok);
        read_api("bad_count", 8'h11, exp_bad);
    endtask

    initial begin
        i_areset = 1'b1;
        i_clear = 1'b0;
        i_rx_wr_en = 1'b0;
        i_rx_block = 3'd0;
        i_rx_data = 64'd0;
        i_api_cs = 1'b0;
        i_api_we = 1'b0;
        i_api_address = 8'h00;
        i_api_write_data = 32'd0;
        exp_ok = 32'd0;
        exp_bad = 32'd0;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_error", 64'(o_error), 64'd0);
        check("rst_fields", {o_version_number, o_mode, o_poll}, 64'd0);
        check("rst_origin", o_origin_timestamp, 64'd0);
        i_areset = 1'b0;
        read_api("name0", 8'h00, 32'h6e74_7068);
        read_api("name1", 8'h01, 32'h6864_7278);
        read_api("version", 8'h02, 32'h302e_3031);
        read_api("unmapped", 8'h05, 32'd0);
        read_api("rst_ok", 8'h10, 32'd0);
        tick();

        // Back-to-back valid packet; check the block 0 capture and timestamp pulse
        send_block(3'd0, B0_GOOD);
        check("rec_ts_pulse", 64'(o_record_receive_timestamp), 64'd1);
        check("busy_receive", 64'(o_busy), 64'd1);
        check("vn", 64'(o_version_number), 64'd4);
        check("mode", 64'(o_mode), 64'd3);
        check("poll", 64'(o_poll), 64'd6);
        for (int b = 1; b <= 4; b++) send_block(3'(b), 64'(b));
        check("rec_ts_single", 64'(o_record_receive_timestamp), 64'd0);
        sb.push_back({1'b1, ORIGIN1});
        send_block(3'd5, ORIGIN1);
        check("done_pulse_b2b", 64'(o_done), 64'd1);
        exp_ok = exp_ok + 32'd1;
        tick();
        check("origin_b2b", o_origin_timestamp, ORIGIN1);
        read_api("ok_count_b2b", 8'h10, exp_ok);

        // Same packet with idle gap, then a Mode=4 packet
        send_packet(B0_GOOD, ORIGIN1, 3);
        send_packet(B0_MODE4, ORIGIN2, 0);
        check("mode4", 64'(o_mode), 64'd4);

        // Out-of-order block: ERROR, writes ignored, cleared by i_clear
        send_block(3'd0, B0_GOOD);
        send_block(3'd1, 64'd1);
        send_block(3'd3, 64'd3);
        exp_bad = exp_bad + 32'd1;
        check("err_error", 64'(o_error), 64'd1);
        check("err_busy", 64'(o_busy), 64'd1);
        send_block(3'd2, 64'd2);
        send_block(3'd0, B0_VN3);
        check("err_no_rec_ts", 64'(o_record_receive_timestamp), 64'd0);
        check("err_holds", 64'(o_error), 64'd1);
        check("err_vn_held", 64'(o_version_number), 64'd4);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check("clear_idle", 64'(o_busy), 64'd0);
        check("clear_error", 64'(o_error), 64'd0);
        read_api("err_bad_count", 8'h11, exp_bad);

        // Clear coinciding with block 5: no verdict, no count, origin kept
        send_blocks_0_to_4(B0_VN3, 0);
        i_clear = 1'b1;
        send_block(3'd5, ORIGIN1);
        i_clear = 1'b0;
        check("clr5_busy", 64'(o_busy), 64'd0);
        check("clr5_done", 64'(o_done), 64'd0);
        check("clr5_origin", o_origin_timestamp, ORIGIN2);
        check("clr5_vn", 64'(o_version_number), 64'd3);
        tick();
        read_api("clr5_ok", 8'h10, exp_ok);
        read_api("clr5_bad", 8'h11, exp_bad);

        // Stray block in IDLE goes straight to ERROR
        send_block(3'd4, 64'd4);
        exp_bad = exp_bad + 32'd1;
        check("idle_stray_error", 64'(o_error), 64'd1);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;

        // Asynchronous reset mid-packet
        send_block(3'd0, B0_GOOD);
        send_block(3'd1, 64'd1);
        send_block(3'd2, 64'd2);
        i_areset = 1'b1;
        #2;
        check("arst_busy", 64'(o_busy), 64'd0);
        check("arst_fields", {o_version_number, o_mode, o_poll}, 64'd0);
        check("arst_origin", o_origin_timestamp, 64'd0);
        @(posedge i_clk);
        #1;
        i_areset = 1'b0;
        exp_ok = 32'd0;
        exp_bad = 32'd0;
        idle(2);
        send_packet(B0_GOOD, ORIGIN1, 0);
        write_api(8'h12, 32'hFFFF_FFFF);
        exp_ok = 32'd0;
        exp_bad = 32'd0;
        read_api("apiclr_ok", 8'h10, exp_ok);
        read_api("apiclr_bad", 8'h11, exp_bad);

        // API clear in the DONE cycle beats the count event; other writes are no-ops
        send_blocks_0_to_4(B0_MODE4, 0);
        sb.push_back({1'b0, ORIGIN2});
        send_block(3'd5, ORIGIN2);
        write_api(8'h12, 32'd0);
        read_api("clr_wins_bad", 8'h11, 32'd0);
        send_packet(B0_VN3, ORIGIN1, 1);
        write_api(8'h10, 32'h0000_0055);
        read_api("noop_write_ok", 8'h10, exp_ok);

        idle(3);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
